pry2oht_rr_arb: RTL and testbench

PRY2OHT_RR_ARB -- requirements
Module: pry2oht_rr_arb

---
 rtl/pry2oht_pkg.sv | 13 +
 rtl/pry2oht_bck_tree.sv | 81 ++++++++
 rtl/pry2oht_rr_arb.sv | 79 +++++++
 tb/tb_pry2oht_rr_arb.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/pry2oht_pkg.sv
// Shared constants and helpers for the priority-to-one-hot arbiter family.
// Search-direction names and the grant index width are defined here.
package pry2oht_pkg;

    localparam string DIR_LSB = "LSB";
    localparam string DIR_MSB = "MSB";

    // Floor of 1 keeps a single-requester build from producing a zero-width index port.
    function automatic int idx_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/pry2oht_bck_tree.sv
// Recursive priority tree: picks the first set request in search order and returns it one-hot.
// Each node splits its input into SPLIT equal branches; leaves resolve at most SPLIT bits.
module pry2oht_bck_tree
    import pry2oht_pkg::*;
#(
    parameter int    WIDTH          = 32,
    parameter int    SPLIT          = 2,
    parameter string DIRECTION      = "LSB",
    parameter int    IMPLEMENTATION = 0
) (
    input  logic [WIDTH-1:0] req,
    output logic             vld,
    output logic [WIDTH-1:0] oht
);

    localparam bit MSB_FIRST = (DIRECTION == DIR_MSB);

    assign vld = |req;

    if (WIDTH <= SPLIT) begin : g_leaf
        if (IMPLEMENTATION == 0) begin : g_loop
            // Walk against search order so the last hit written is the highest-priority one.
            always_comb begin
                oht = '0;
                for (int i = 0; i < WIDTH; i++) begin
                    int p;
                    p = MSB_FIRST ? i : (WIDTH - 1 - i);
                    if (req[p]) begin
                        oht    = '0;
                        oht[p] = 1'b1;
                    end
                end
            end
        end else begin : g_isolate
            // Two's-complement lowest-set-bit isolation, mirrored for descending search.
            logic [WIDTH-1:0] rr, ro;
            always_comb begin
                rr = '0;
                for (int i = 0; i < WIDTH; i++)
                    rr[i] = MSB_FIRST ? req[WIDTH-1-i] : req[i];
                ro  = rr & (~rr + 1'b1);
                oht = '0;
                for (int i = 0; i < WIDTH; i++)
                    oht[i] = MSB_FIRST ? ro[WIDTH-1-i] : ro[i];
            end
        end
    end else begin : g_node
        localparam int SUB = WIDTH / SPLIT;

        logic [SPLIT-1:0]          c_vld;
        logic [SPLIT-1:0]          c_sel;
        logic [SPLIT-1:0][SUB-1:0] c_oht;

        for (genvar g = 0; g < SPLIT; g++) begin : g_br
            pry2oht_bck_tree #(
                .WIDTH         (SUB),
                .SPLIT         (SPLIT),
                .DIRECTION     (DIRECTION),
                .IMPLEMENTATION(IMPLEMENTATION)
            ) u_br (
                .req(req[g*SUB +: SUB]),
                .vld(c_vld[g]),
                .oht(c_oht[g])
            );
            assign oht[g*SUB +: SUB] = c_sel[g] ? c_oht[g] : '0;
        end

        always_comb begin
            c_sel = '0;
            for (int i = 0; i < SPLIT; i++) begin
                int p;
                p = MSB_FIRST ? i : (SPLIT - 1 - i);
                if (c_vld[p]) begin
                    c_sel    = '0;
                    c_sel[p] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pry2oht_rr_arb.sv
// Round-robin arbiter with a registered one-hot/binary grant and valid/ready handshake.
// The mask of the just-transferred grant is applied in the same cycle, so back-to-back grants have no bubble.
module pry2oht_rr_arb
    import pry2oht_pkg::*;
#(
    parameter int    WIDTH          = 32,
    parameter int    SPLIT          = 2,
    parameter string DIRECTION      = "LSB",
    parameter int    IMPLEMENTATION = 0,
    localparam int   IW             = idx_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] req,
    output logic             gnt_vld,
    input  logic             gnt_rdy,
    output logic [WIDTH-1:0] gnt_oht,
    output logic [IW-1:0]    gnt_idx,
    output logic [WIDTH-1:0] msk
);

    localparam bit MSB_FIRST = (DIRECTION == DIR_MSB);

    logic             xfr, arb;
    logic [WIDTH-1:0] msk_post, msk_nxt, req_m;
    logic             m_vld, u_vld;
    logic [WIDTH-1:0] m_oht, u_oht, win;
    logic [IW-1:0]    win_idx;

    assign xfr = gnt_vld & gnt_rdy;
    assign arb = ~gnt_vld | xfr;

    // Requesters strictly past the current grant in search order; empty after the last index.
    always_comb begin
        msk_post = '0;
        for (int i = 0; i < WIDTH; i++)
            msk_post[i] = MSB_FIRST ? (i < int'(gnt_idx)) : (i > int'(gnt_idx));
    end

    assign msk_nxt = xfr ? msk_post : msk;
    assign req_m   = req & msk_nxt;

    pry2oht_bck_tree #(
        .WIDTH(WIDTH), .SPLIT(SPLIT), .DIRECTION(DIRECTION), .IMPLEMENTATION(IMPLEMENTATION)
    ) u_tree_m (
        .req(req_m), .vld(m_vld), .oht(m_oht)
    );

    pry2oht_bck_tree #(
        .WIDTH(WIDTH), .SPLIT(SPLIT), .DIRECTION(DIRECTION), .IMPLEMENTATION(IMPLEMENTATION)
    ) u_tree_u (
        .req(req), .vld(u_vld), .oht(u_oht)
    );

    assign win = m_vld ? m_oht : u_oht;

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < WIDTH; i++)
            if (win[i]) win_idx = win_idx | IW'(i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_vld <= 1'b0;
            gnt_oht <= '0;
            gnt_idx <= '0;
            msk     <= '1;
        end else begin
            if (xfr) msk <= msk_post;
            if (arb) begin
                gnt_vld <= u_vld;
                gnt_oht <= u_vld ? win : '0;
                if (u_vld) gnt_idx <= win_idx;
            end
        end
    end

endmodule

// File: tb/tb_pry2oht_rr_arb.sv
// Scoreboard bench: an LSB and an MSB arbiter share stimulus; a rotating-pointer model predicts both.
// Expectations are queued at stimulus time and checked by an independent monitor after each edge.
module tb_pry2oht_rr_arb;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [7:0]      req = '0;
    logic            gnt_rdy = 1'b0;
    logic [1:0]      dv;
    logic [1:0][7:0] doht, dmsk;
    logic [1:0][2:0] didx;

    always #5 clk = ~clk;

    pry2oht_rr_arb #(.WIDTH(8), .SPLIT(2), .DIRECTION("LSB"), .IMPLEMENTATION(0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .req(req), .gnt_vld(dv[0]), .gnt_rdy(gnt_rdy),
        .gnt_oht(doht[0]), .gnt_idx(didx[0]), .msk(dmsk[0])
    );

    pry2oht_rr_arb #(.WIDTH(8), .SPLIT(2), .DIRECTION("MSB"), .IMPLEMENTATION(1)) u_msb (
        .clk(clk), .rst_n(rst_n), .req(req), .gnt_vld(dv[1]), .gnt_rdy(gnt_rdy),
        .gnt_oht(doht[1]), .gnt_idx(didx[1]), .msk(dmsk[1])
    );

    typedef struct packed {
        logic [1:0]      vld;
        logic [1:0][7:0] oht;
        logic [1:0][2:0] idx;
        logic [1:0][7:0] msk;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Model: m_ptr is where the next circular search starts (LSB may reach 8, MSB may reach -1).
    int m_vld[2], m_idx[2], m_ptr[2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void mreset();
        for (int d = 0; d < 2; d++) begin
            m_vld[d] = 0;
            m_idx[d] = 0;
            m_ptr[d] = (d == 0) ? 0 : 7;
        end
    endfunction

    function automatic void mstep(input int d, input logic [7:0] r, input logic rdy);
        bit xf, ar;
        int s, p;
        xf = (m_vld[d] != 0) && rdy;
        ar = (m_vld[d] == 0) || xf;
        if (xf) m_ptr[d] = (d == 0) ? m_idx[d] + 1 : m_idx[d] - 1;
        if (ar) begin
            if (r == 8'h00) m_vld[d] = 0;
            else begin
                s = (m_ptr[d] + 8) % 8;
                for (int k = 0; k < 8; k++) begin
                    p = (d == 0) ? (s + k) % 8 : (s - k + 8) % 8;
                    if (r[p]) begin
                        m_idx[d] = p;
                        break;
                    end
                end
                m_vld[d] = 1;
            end
        end
    endfunction

    function automatic exp_t mexp();
        exp_t e;
        e = '0;
        for (int d = 0; d < 2; d++) begin
            e.vld[d] = (m_vld[d] != 0);
            e.oht[d] = (m_vld[d] != 0) ? 8'(1 << m_idx[d]) : 8'h00;
            e.idx[d] = 3'(m_idx[d]);
            for (int i = 0; i < 8; i++)
                e.msk[d][i] = (d == 0) ? (i >= m_ptr[d]) : (i <= m_ptr[d]);
        end
        return e;
    endfunction

    task automatic cycle(input logic [7:0] r, input logic rdy, input logic rs);
        @(negedge clk);
        req = r;
        gnt_rdy = rdy;
        rst_n = rs;
        if (!rs) begin
            mreset();
            #1;
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("d%0d async vld", d), 32'(dv[d]), 0);
                chk($sformatf("d%0d async oht", d), 32'(doht[d]), 0);
                chk($sformatf("d%0d async msk", d), 32'(dmsk[d]), 32'hFF);
            end
        end else begin
            mstep(0, r, rdy);
            mstep(1, r, rdy);
        end
        q.push_back(mexp());
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                for (int d = 0; d < 2; d++) begin
                    chk($sformatf("d%0d gnt_vld", d), 32'(dv[d]), 32'(e.vld[d]));
                    chk($sformatf("d%0d gnt_oht", d), 32'(doht[d]), 32'(e.oht[d]));
                    chk($sformatf("d%0d gnt_idx", d), 32'(didx[d]), 32'(e.idx[d]));
                    chk($sformatf("d%0d msk", d), 32'(dmsk[d]), 32'(e.msk[d]));
                end
            end
        end
    end

    initial begin : stim
        logic [7:0] r;
        mreset();
        cycle(8'h00, 1'b0, 1'b0);
        cycle(8'h00, 1'b0, 1'b0);
        // 2,4,2,4 with wrap
        repeat (4) cycle(8'b0001_0100, 1'b1, 1'b1);
        cycle(8'h00, 1'b1, 1'b1);
        // full rotation twice
        repeat (17) cycle(8'hFF, 1'b1, 1'b1);
        // hold idx 3 while req changes, then idx 0
        cycle(8'h00, 1'b1, 1'b1);
        cycle(8'h08, 1'b0, 1'b1);
        repeat (5) cycle(8'h01, 1'b0, 1'b1);
        cycle(8'h01, 1'b1, 1'b1);
        cycle(8'h00, 1'b1, 1'b1);
        // idx 7 accepted, empty mask falls back to idx 0
        cycle(8'h00, 1'b1, 1'b1);
        cycle(8'h80, 1'b1, 1'b1);
        cycle(8'h81, 1'b1, 1'b1);
        cycle(8'h00, 1'b1, 1'b1);
        // MSB 7,0,7 from a fresh reset
        cycle(8'h00, 1'b0, 1'b0);
        repeat (3) cycle(8'h81, 1'b1, 1'b1);
        // reset while a grant is pending, then 0x30
        cycle(8'h00, 1'b1, 1'b1);
        cycle(8'h30, 1'b0, 1'b1);
        cycle(8'h30, 1'b0, 1'b1);
        cycle(8'h30, 1'b0, 1'b0);
        cycle(8'h30, 1'b0, 1'b0);
        repeat (2) cycle(8'h30, 1'b1, 1'b1);
        // random traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) r = 8'(1 << $urandom_range(0, 7));
            else if ($urandom_range(0, 9) == 0) r = 8'h00;
            else r = 8'($urandom);
            cycle(r, $urandom_range(0, 2) != 0, $urandom_range(0, 60) != 0);
        end
        repeat (2) @(posedge clk);
        #2;
        chk("scoreboard drain", 32'(q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
